// File: rtl/adpcm_pkg.sv
// Purpose : shared widths and constants for the ADPCM sample-to-float converter.
// Latency : n/a (definitions only).
// Backpressure: n/a.
package adpcm_pkg;

  localparam int IN_W   = 16;  // two's-complement input sample
  localparam int MAG_W  = 15;  // magnitude after sign removal
  localparam int EXP_W  = 4;   // bit-length exponent, 0..15
  localparam int MANT_W = 6;   // normalised mantissa, MSB set when MAG != 0
  localparam int PAD_W  = IN_W - 1 - EXP_W - MANT_W;

  // Mantissa reported for a zero magnitude: the implied leading one alone.
  localparam logic [MANT_W-1:0] MANT_ZERO = 6'd32;

endpackage

// File: rtl/adpcm_exp_enc.sv
// Purpose : priority encoder, exp_o = bit length of mag_i (index of top set bit + 1).
// Latency : purely combinational, no clock.
// Backpressure: none; output always valid for the current input.
// Ports   : mag_i [MAG_W-1:0] magnitude in; exp_o [EXP_W-1:0] bit length out (0 for zero).
module adpcm_exp_enc
  import adpcm_pkg::*;
(
  input  logic [MAG_W-1:0] mag_i,
  output logic [EXP_W-1:0] exp_o
);

  // Ascending scan: the last set bit found is the highest, so it wins.
  always_comb begin
    exp_o = '0;
    for (int i = 0; i < MAG_W; i++) begin
      if (mag_i[i]) begin
        exp_o = EXP_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/module_name_core.sv
// Purpose : converts a 16-bit two's-complement sample into {sign, exponent, mantissa} floating form.
// Latency : purely combinational In1 -> Out1, no clock latency.
// Backpressure: none; Out1 tracks In1 continuously, independent of clk/reset/test pins.
// Ports   : clk, reset (async active-low), scan_in0..4 / scan_enable / test_mode (DFT hooks),
//           In1 [15:0] sample in; scan_out0..4 (tied 0 until chains are stitched);
//           Out1 [15:0] = {5'b0, sign, exp[3:0], mant[5:0]}.
module module_name_core
  import adpcm_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            scan_in0,
  input  logic            scan_in1,
  input  logic            scan_in2,
  input  logic            scan_in3,
  input  logic            scan_in4,
  input  logic            scan_enable,
  input  logic            test_mode,
  input  logic [IN_W-1:0] In1,
  output logic            scan_out0,
  output logic            scan_out1,
  output logic            scan_out2,
  output logic            scan_out3,
  output logic            scan_out4,
  output logic [IN_W-1:0] Out1
);

  logic              srs;
  logic [MAG_W-1:0]  mag;
  logic [EXP_W-1:0]  exp_w;
  logic [MANT_W-1:0] mant;

  // The datapath holds no state; clock, reset and DFT pins exist only so the
  // scan-insertion flow has something to stitch. Collected here so they are
  // visibly intentional sinks.
  logic unused_dft;
  assign unused_dft = &{1'b0, clk, reset, scan_in0, scan_in1, scan_in2,
                        scan_in3, scan_in4, scan_enable, test_mode};

  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

  // Sign and magnitude. Negating 0x8000 wraps back to 0x8000, whose low 15
  // bits are zero, so the most negative sample encodes as a signed zero.
  always_comb begin
    srs = In1[IN_W-1];
    if (srs) begin
      mag = MAG_W'(~In1 + 16'd1);
    end else begin
      mag = In1[MAG_W-1:0];
    end
  end

  adpcm_exp_enc u_exp_enc (
    .mag_i (mag),
    .exp_o (exp_w)
  );

  // Normalise: shifting up by MANT_W then down by the bit length parks the
  // leading one at mantissa bit 5; lower magnitude bits beyond that truncate.
  always_comb begin
    mant = MANT_ZERO;
    if (mag != '0) begin
      mant = MANT_W'({mag, {MANT_W{1'b0}}} >> exp_w);
    end
  end

  assign Out1 = {{PAD_W{1'b0}}, srs, exp_w, mant};

endmodule

// File: tb/tb_module_name_core.sv
module tb_module_name_core;

  logic        clk;
  logic        reset;
  logic        scan_in0, scan_in1, scan_in2, scan_in3, scan_in4;
  logic        scan_enable;
  logic        test_mode;
  logic [15:0] In1;
  logic        scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;
  logic [15:0] Out1;

  int total = 0;
  int bad   = 0;

  module_name_core dut (
    .clk         (clk),
    .reset       (reset),
    .scan_in0    (scan_in0),
    .scan_in1    (scan_in1),
    .scan_in2    (scan_in2),
    .scan_in3    (scan_in3),
    .scan_in4    (scan_in4),
    .scan_enable (scan_enable),
    .test_mode   (test_mode),
    .In1         (In1),
    .scan_out0   (scan_out0),
    .scan_out1   (scan_out1),
    .scan_out2   (scan_out2),
    .scan_out3   (scan_out3),
    .scan_out4   (scan_out4),
    .Out1        (Out1)
  );

  // 22 ns period: rising edges fall at odd multiples of 11 ns, never on a sample point.
  initial clk = 1'b0;
  always #11 clk = ~clk;

  // Independent arithmetic reference: integer negation, bit length by
  // repeated halving, mantissa by division.
  function automatic logic [15:0] ref_out(input logic [15:0] x);
    int s, m, e, t, mt;
    s = int'(x[15]);
    if (s == 1) m = (65536 - int'(x)) % 32768;
    else        m = int'(x) % 32768;
    e = 0;
    t = m;
    while (t > 0) begin
      t = t / 2;
      e = e + 1;
    end
    if (m == 0) mt = 32;
    else        mt = (m * 64) / (1 << e);
    return 16'(s * 1024 + e * 64 + mt);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s: observed %h required %h", tag, obs, req);
    end
  endtask

  // Change In1, let it settle 10 ns, compare, then hold 1 ns so changes are 11 ns apart.
  task automatic drive_check(input string tag, input logic [15:0] v, input logic [15:0] req);
    In1 = v;
    #10;
    check(tag, Out1, req);
    #1;
  endtask

  initial begin
    reset       = 1'b0;  // held asserted for the whole run
    scan_in0    = 1'b0;
    scan_in1    = 1'b0;
    scan_in2    = 1'b0;
    scan_in3    = 1'b0;
    scan_in4    = 1'b0;
    scan_enable = 1'b0;
    test_mode   = 1'b0;
    In1         = 16'h0000;
    #3;

    // Scan outputs are tied low while in reset.
    #10;
    check("scan_out_reset", {11'd0, scan_out4, scan_out3, scan_out2, scan_out1, scan_out0}, 16'h0000);
    #1;

    // Directed vectors, expected values worked by hand.
    drive_check("zero",        16'h0000, 16'h0020);
    drive_check("one",         16'h0001, 16'h0060);
    drive_check("pos_full",    16'h7FFF, 16'h03FF);
    drive_check("mid_0100",    16'h0100, 16'h0260);
    drive_check("neg_one",     16'hFFFF, 16'h0460);
    drive_check("most_neg",    16'h8000, 16'h0420);
    drive_check("pos_0003",    16'h0003, 16'h00B0);  // exp 2, mant 48
    drive_check("pos_4000",    16'h4000, 16'h03E0);  // exp 15, mant 32
    drive_check("neg_8001",    16'h8001, 16'h07FF);  // mag 0x7FFF
    drive_check("neg_fff0",    16'hFFF0, 16'h0560);  // mag 16: exp 5, mant 32
    drive_check("pos_00FF",    16'h00FF, 16'h023F);  // exp 8, mant 63 truncated

    // DFT pins toggled: datapath must not care.
    scan_enable = 1'b1;
    test_mode   = 1'b1;
    scan_in0 = 1'b1; scan_in1 = 1'b1; scan_in2 = 1'b1; scan_in3 = 1'b1; scan_in4 = 1'b1;
    drive_check("dft_on_0100", 16'h0100, 16'h0260);
    check("scan_out_dft", {11'd0, scan_out4, scan_out3, scan_out2, scan_out1, scan_out0}, 16'h0000);
    scan_enable = 1'b0;
    test_mode   = 1'b0;
    scan_in0 = 1'b0; scan_in1 = 1'b0; scan_in2 = 1'b0; scan_in3 = 1'b0; scan_in4 = 1'b0;

    // Exhaustive sweep against the reference model.
    for (int v = 0; v < 65536; v++) begin
      drive_check("sweep", 16'(v), ref_out(16'(v)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
